add: RTL and testbench

64-bit signed two's-complement adder for the Y86 ALU, with a registered result and a signed-overflow flag. It computes the ADD operation (Y86 `addq`) for the execute stage; its overflow output feeds the condition-code OF bit. Operands are sampled on the clock edge, and the result appears one cycle later.

---
 rtl/add.sv | 53 +++++
 tb/tb_add.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/add.sv
// Y86 execute-stage 64-bit adder: a structural ripple-carry chain of full-adder
// cells feeding registered SUM/CARRY_OVERFLOW/out_valid outputs.
module add (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        in_valid,
    output logic [63:0] SUM,
    output logic        CARRY_OVERFLOW,
    output logic        out_valid
);

    logic [64:0] w_carry;
    logic [63:0] w_sum;
    logic        w_ovf;

    logic [63:0] r_sum;
    logic        r_ovf;
    logic        r_valid;

    assign w_carry[0] = 1'b0;

    // One full-adder cell per bit; the carry out of bit 63 only feeds the overflow test.
    for (genvar i = 0; i < 64; i++) begin : g_fa
        assign w_sum[i]     = A[i] ^ B[i] ^ w_carry[i];
        assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end

    assign w_ovf = w_carry[63] ^ w_carry[64];

    // Output registers: load on a valid pair, hold the result otherwise; reset wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= 64'd0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_sum   <= w_sum;
            r_ovf   <= w_ovf;
            r_valid <= 1'b1;
        end else begin
            r_sum   <= r_sum;
            r_ovf   <= r_ovf;
            r_valid <= 1'b0;
        end
    end

    assign SUM            = r_sum;
    assign CARRY_OVERFLOW = r_ovf;
    assign out_valid      = r_valid;

endmodule

// File: tb/tb_add.sv
// Self-checking bench for add: directed corner vectors, reset behaviour and
// randomized operands against a wide-arithmetic reference model.
module tb_add;

    logic        clk;
    logic        rst;
    logic [63:0] A;
    logic [63:0] B;
    logic        in_valid;
    logic [63:0] SUM;
    logic        CARRY_OVERFLOW;
    logic        out_valid;

    int n_checks;
    int n_fails;

    logic [63:0] exp_sum;
    logic        exp_ovf;
    logic        exp_valid;

    add dut (
        .clk            (clk),
        .rst            (rst),
        .A              (A),
        .B              (B),
        .in_valid       (in_valid),
        .SUM            (SUM),
        .CARRY_OVERFLOW (CARRY_OVERFLOW),
        .out_valid      (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: true sign-extended sum must fit in the signed 64-bit range.
    function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] ext;
        ext = $signed({a[63], a}) + $signed({b[63], b});
        return (ext > $signed({1'b0, 64'h7FFF_FFFF_FFFF_FFFF})) ||
               (ext < $signed({1'b1, 64'h8000_0000_0000_0000}));
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_sum"},   SUM,                      exp_sum);
        check({tag, "_ovf"},   {63'd0, CARRY_OVERFLOW},  {63'd0, exp_ovf});
        check({tag, "_valid"}, {63'd0, out_valid},       {63'd0, exp_valid});
    endtask

    task automatic step(input string tag, input logic v, input logic [63:0] a, input logic [63:0] b);
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        if (v) begin
            exp_sum = a + b;
            exp_ovf = ref_ovf(a, b);
        end
        exp_valid = v;
        check_outputs(tag);
    endtask

    logic [63:0] dir_a   [4];
    logic [63:0] dir_b   [4];
    logic [63:0] dir_sum [4];
    logic        dir_ovf [4];

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        exp_sum   = 64'd0;
        exp_ovf   = 1'b0;
        exp_valid = 1'b0;

        dir_a[0] = 64'h8000_0000_0000_0001; dir_b[0] = 64'h8000_0000_0000_0003;
        dir_sum[0] = 64'h0000_0000_0000_0004; dir_ovf[0] = 1'b1;
        dir_a[1] = 64'h7FFF_FFFF_FFFF_FFFE; dir_b[1] = 64'h8000_0000_0000_0003;
        dir_sum[1] = 64'h0000_0000_0000_0001; dir_ovf[1] = 1'b0;
        dir_a[2] = 64'h8000_0000_0000_0001; dir_b[2] = 64'h7FFF_FFFF_FFFF_FFFC;
        dir_sum[2] = 64'hFFFF_FFFF_FFFF_FFFD; dir_ovf[2] = 1'b0;
        dir_a[3] = 64'h7FFF_FFFF_FFFF_FFFE; dir_b[3] = 64'h7FFF_FFFF_FFFF_FFFC;
        dir_sum[3] = 64'hFFFF_FFFF_FFFF_FFFA; dir_ovf[3] = 1'b1;

        // Reset with valid operands present: outputs must be zero immediately and across edges.
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 64'h1234_5678_9ABC_DEF0;
        B        = 64'h0FED_CBA9_8765_4321;
        #1;
        check_outputs("rst_immediate");
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst_held");

        rst = 1'b0;
        step("first_after_rst", 1'b1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007);
        check("first_after_rst_const", SUM, 64'h0000_0000_0000_000C);

        // Directed vectors back to back, then a hold cycle.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("dir%0d", i), 1'b1, dir_a[i], dir_b[i]);
            check($sformatf("dir%0d_sum_const", i), SUM, dir_sum[i]);
            check($sformatf("dir%0d_ovf_const", i), {63'd0, CARRY_OVERFLOW}, {63'd0, dir_ovf[i]});
        end
        step("hold", 1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
        check("hold_sum_const", SUM, 64'hFFFF_FFFF_FFFF_FFFA);
        check("hold_ovf_const", {63'd0, CARRY_OVERFLOW}, 64'd1);
        step("hold2", 1'b0, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);

        // Mid-stream asynchronous reset discards the in-flight result.
        step("pre_rst", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
        in_valid = 1'b1;
        A        = 64'hAAAA_AAAA_AAAA_AAAA;
        B        = 64'h5555_5555_5555_5555;
        #2;
        rst = 1'b1;
        #1;
        exp_sum   = 64'd0;
        exp_ovf   = 1'b0;
        exp_valid = 1'b0;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_beats_valid");
        rst = 1'b0;
        step("post_rst", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002);

        // Randomized operands, biased toward sign-boundary values now and then.
        for (int i = 0; i < 10000; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rv;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = {ra[63], {12{~ra[63]}}, ra[50:0]};
            if ($urandom_range(0, 7) == 0) rb = {rb[63], {12{~rb[63]}}, rb[50:0]};
            rv = ($urandom_range(0, 9) != 0);
            step("rand", rv, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
